// File: rtl/multiplier_inverse_divider_pkg.sv
// Shared definitions for the restoring divider.
// Holds the FSM state encoding, the default operand widths and the
// step-counter width (enough bits to count N_W restoring steps).
package div_pkg;

  localparam int N_W_DEF = 4;
  localparam int D_W_DEF = 2;

  // Step-counter width for a given dividend width.
  function automatic int cnt_width(input int n_w);
    return $clog2(n_w + 1);
  endfunction

  localparam int STEP_CNT_W = $clog2(N_W_DEF + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/multiplier_inverse_divider_if.sv
// Handshake bundle between a producer/consumer and the divider.
//   master : drives in_valid, dividend, divisor, out_ready
//   slave  : drives in_ready, out_valid, quotient, remainder, div_by_zero
interface multiplier_inverse_divider_if #(
  parameter int N_W = 4,
  parameter int D_W = 2
);
  logic           in_valid;
  logic           in_ready;
  logic [N_W-1:0] dividend;
  logic [D_W-1:0] divisor;
  logic           out_valid;
  logic           out_ready;
  logic [N_W-1:0] quotient;
  logic [D_W-1:0] remainder;
  logic           div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/multiplier_inverse_divider_step.sv
// divider_step: one combinational restoring-division step.
//   partial_in  [D_W:0]   partial remainder before the step
//   next_bit              next dividend bit (MSB first)
//   divisor     [D_W-1:0] divisor
//   partial_out [D_W:0]   partial remainder after the step
//   q_bit                 quotient bit produced by this step
module divider_step #(
  parameter int D_W = 2
) (
  input  logic [D_W:0]   partial_in,
  input  logic           next_bit,
  input  logic [D_W-1:0] divisor,
  output logic [D_W:0]   partial_out,
  output logic           q_bit
);

  // Keep the shifted value one bit wider so no information is dropped
  // even if partial_in ever carried a set MSB.
  logic [D_W+1:0] shifted;
  logic [D_W:0]   trial;

  assign shifted = {partial_in, next_bit};
  // A non-negative trial difference is the same as shifted >= divisor.
  assign q_bit   = (shifted >= (D_W+2)'(divisor));
  assign trial   = (D_W+1)'(shifted - (D_W+2)'(divisor));

  assign partial_out = q_bit ? trial : shifted[D_W:0];

endmodule

// File: rtl/multiplier_inverse_divider.sv
// Sequential restoring divider with valid/ready handshakes.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : slave side of multiplier_inverse_divider_if
// One quotient bit per cycle, dividend MSB first; a zero divisor
// short-circuits to an all-ones quotient with div_by_zero set.
//
// state | meaning
// IDLE  | in_ready = 1, waiting for an operand pair
// BUSY  | running restoring steps (or resolving a zero divisor)
// DONE  | out_valid = 1, result held until out_ready
module multiplier_inverse_divider
  import div_pkg::*;
#(
  parameter int N_W = N_W_DEF,
  parameter int D_W = D_W_DEF
) (
  input logic                          clk,
  input logic                          rst_n,
  multiplier_inverse_divider_if.slave  bus
);

  localparam int CNT_W = cnt_width(N_W);

  state_t         state_q,     state_d;
  logic [N_W-1:0] dividend_q,  dividend_d;
  logic [D_W-1:0] divisor_q,   divisor_d;
  logic [D_W:0]   partial_q,   partial_d;
  logic [CNT_W-1:0] count_q,   count_d;
  logic [N_W-1:0] quotient_q,  quotient_d;
  logic [D_W-1:0] remainder_q, remainder_d;
  logic           dbz_q,       dbz_d;
  logic           in_ready_q,  in_ready_d;
  logic           out_valid_q, out_valid_d;

  logic [D_W:0]   step_partial;
  logic           step_q_bit;

  // Dividend register shifts left each step, so its MSB is always the
  // next bit to bring down.
  divider_step #(.D_W(D_W)) u_step (
    .partial_in  (partial_q),
    .next_bit    (dividend_q[N_W-1]),
    .divisor     (divisor_q),
    .partial_out (step_partial),
    .q_bit       (step_q_bit)
  );

  always_comb begin
    state_d     = state_q;
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    partial_d   = partial_q;
    count_d     = count_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          dividend_d  = bus.dividend;
          divisor_d   = bus.divisor;
          partial_d   = '0;
          count_d     = '0;
          quotient_d  = '0;
          remainder_d = '0;
          dbz_d       = 1'b0;
          state_d     = ST_BUSY;
        end
      end

      ST_BUSY: begin
        if (divisor_q == '0) begin
          quotient_d  = '1;
          remainder_d = '0;
          dbz_d       = 1'b1;
          state_d     = ST_DONE;
        end else begin
          partial_d  = step_partial;
          dividend_d = {dividend_q[N_W-2:0], 1'b0};
          quotient_d = {quotient_q[N_W-2:0], step_q_bit};
          count_d    = count_q + CNT_W'(1);
          if (count_q == CNT_W'(N_W - 1)) begin
            // After the last step the partial remainder fits in D_W bits.
            remainder_d = D_W'(step_partial);
            state_d     = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      dividend_q  <= '0;
      divisor_q   <= '0;
      partial_q   <= '0;
      count_q     <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      partial_q   <= partial_d;
      count_q     <= count_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_multiplier_inverse_divider.sv
// Self-checking bench for multiplier_inverse_divider (N_W=4, D_W=2).
// Expected results come from plain integer division and the identity
// q*d + r == n; latencies come from the handshake timing rules.
module tb_multiplier_inverse_divider;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  multiplier_inverse_divider_if #(.N_W(4), .D_W(2)) bus ();

  multiplier_inverse_divider #(.N_W(4), .D_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one operation; returns observed latency (-1 on timeout),
  // the presented result and whether IDLE followed the handshake.
  task automatic run_op(input logic [3:0] a, input logic [1:0] b, input bit rdy_early,
                        output int lat, output logic [3:0] q, output logic [1:0] r,
                        output logic z, output logic idle_after);
    int guard;
    guard = 0;
    lat = -1;
    q = 'x; r = 'x; z = 1'bx; idle_after = 1'b0;
    while (bus.in_ready !== 1'b1 && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    bus.dividend  = a;
    bus.divisor   = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = rdy_early;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.dividend = 4'($urandom);
    bus.divisor  = 2'($urandom);
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
    if (lat > 0) begin
      q = bus.quotient;
      r = bus.remainder;
      z = bus.div_by_zero;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      idle_after = (bus.in_ready === 1'b1) && (bus.out_valid === 1'b0);
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.dividend = '0; bus.divisor = '0;
    #12;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.quotient !== 4'd0 || bus.remainder !== 2'd0 ||
        bus.div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b q=%0d r=%0d z=%b, want v=0 q=0 r=0 z=0",
               bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_basic();
    int lat; logic [3:0] q; logic [1:0] r; logic z, idle;
    logic [3:0] na [3]; logic [1:0] nb [3];
    na[0] = 4'd11; nb[0] = 2'd3;
    na[1] = 4'd15; nb[1] = 2'd1;
    na[2] = 4'd0;  nb[2] = 2'd2;
    for (int k = 0; k < 3; k++) begin
      logic [3:0] eq; logic [1:0] er;
      eq = 4'(int'(na[k]) / int'(nb[k]));
      er = 2'(int'(na[k]) % int'(nb[k]));
      run_op(na[k], nb[k], (k == 0), lat, q, r, z, idle);
      checks++;
      if (lat != 4 || q !== eq || r !== er || z !== 1'b0 || idle !== 1'b1) begin
        errors++;
        $display("FAIL basic_%0d/%0d: got lat=%0d q=%0d r=%0d z=%b idle=%b, want lat=4 q=%0d r=%0d z=0 idle=1",
                 na[k], nb[k], lat, q, r, z, idle, eq, er);
      end
    end
  endtask

  task automatic test_div_zero();
    int lat; logic [3:0] q; logic [1:0] r; logic z, idle;
    run_op(4'd9, 2'd0, 1'b0, lat, q, r, z, idle);
    checks++;
    if (lat != 1 || q !== 4'd15 || r !== 2'd0 || z !== 1'b1 || idle !== 1'b1) begin
      errors++;
      $display("FAIL div_zero: got lat=%0d q=%0d r=%0d z=%b idle=%b, want lat=1 q=15 r=0 z=1 idle=1",
               lat, q, r, z, idle);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    lat = -1;
    bus.dividend = 4'd14; bus.divisor = 2'd3; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    // Keep offering a different pair through BUSY and DONE; it must be ignored.
    bus.dividend = 4'd15; bus.divisor = 2'd1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) begin lat = i; break; end
    end
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL bp_latency: got %0d want 4", lat);
    end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.quotient !== 4'd4 || bus.remainder !== 2'd2 ||
          bus.div_by_zero !== 1'b0 || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d: got v=%b q=%0d r=%0d z=%b rdy=%b, want v=1 q=4 r=2 z=0 rdy=0",
                 c, bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero, bus.in_ready);
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: got rdy=%b v=%b, want rdy=1 v=0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic [3:0] q; logic [1:0] r; logic z, idle;
    bit seen;
    bus.dividend = 4'd13; bus.divisor = 2'd2; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.quotient !== 4'd0 || bus.remainder !== 2'd0 ||
        bus.div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL midreset_clear: got v=%b q=%0d r=%0d z=%b, want all 0",
               bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero);
    end
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL midreset_no_valid: got out_valid pulse, want none");
    end
    run_op(4'd6, 2'd3, 1'b1, lat, q, r, z, idle);
    checks++;
    if (lat != 4 || q !== 4'd2 || r !== 2'd0 || z !== 1'b0) begin
      errors++;
      $display("FAIL midreset_followup: got lat=%0d q=%0d r=%0d z=%b, want lat=4 q=2 r=0 z=0",
               lat, q, r, z);
    end
  endtask

  task automatic test_sweep();
    int lat; logic [3:0] q; logic [1:0] r; logic z, idle;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 4; b++) begin
        run_op(4'(a), 2'(b), 1'b0, lat, q, r, z, idle);
        checks++;
        if (b != 0) begin
          // Product of the 2x2 multiplier plus remainder must rebuild the dividend.
          if (lat != 4 || (int'(q) * b + int'(r)) != a || int'(r) >= b || z !== 1'b0 || idle !== 1'b1) begin
            errors++;
            $display("FAIL sweep_%0d/%0d: got lat=%0d q=%0d r=%0d z=%b, want q*d+r=%0d r<%0d z=0",
                     a, b, lat, q, r, z, a, b);
          end
        end else begin
          if (lat != 1 || q !== 4'd15 || r !== 2'd0 || z !== 1'b1 || idle !== 1'b1) begin
            errors++;
            $display("FAIL sweep_%0d/0: got lat=%0d q=%0d r=%0d z=%b, want lat=1 q=15 r=0 z=1",
                     a, lat, q, r, z);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    int lat; logic [3:0] q; logic [1:0] r; logic z, idle;
    for (int k = 0; k < 40; k++) begin
      int a, b, elat; logic [3:0] eq; logic [1:0] er; logic ez;
      a = $urandom_range(15, 0);
      b = $urandom_range(3, 0);
      if (b == 0) begin elat = 1; eq = 4'd15; er = 2'd0; ez = 1'b1; end
      else begin elat = 4; eq = 4'(a / b); er = 2'(a % b); ez = 1'b0; end
      run_op(4'(a), 2'(b), bit'($urandom_range(1, 0)), lat, q, r, z, idle);
      checks++;
      if (lat != elat || q !== eq || r !== er || z !== ez || idle !== 1'b1) begin
        errors++;
        $display("FAIL random_%0d/%0d: got lat=%0d q=%0d r=%0d z=%b idle=%b, want lat=%0d q=%0d r=%0d z=%b idle=1",
                 a, b, lat, q, r, z, idle, elat, eq, er, ez);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_div_zero();
    test_backpressure();
    test_reset_mid();
    test_sweep();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multiplier_inverse_divider.md
MULTIPLIER_INVERSE_DIVIDER -- requirements
Module: multiplier_inverse_divider

Interface
REQ-001 Parameter N_W, default 4: dividend and quotient width (matches the 2x2 multiplier product width P).
REQ-002 Parameter D_W, default 2: divisor and remainder width (matches the multiplier operand width).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 in_valid  input  1  dividend/divisor pair is offered.
REQ-006 in_ready  output  1  block can accept a new pair.
REQ-007 dividend  input  N_W  unsigned dividend.
REQ-008 divisor  input  D_W  unsigned divisor.
REQ-009 out_valid  output  1  result is presented.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 quotient  output  N_W  unsigned quotient.
REQ-012 remainder  output  D_W  unsigned remainder.
REQ-013 div_by_zero  output  1  the presented result came from divisor == 0.

Function
REQ-014 The state machine SHALL have three states: IDLE, BUSY and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE. out_valid SHALL be 1 only in DONE.
REQ-016 Accept SHALL occur on a rising edge with in_valid && in_ready.
- dividend and divisor are latched.
- The partial remainder and the step counter are cleared.
REQ-017 On accept with divisor != 0, the block SHALL enter BUSY. It SHALL perform one restoring step per cycle for exactly N_W cycles, MSB of the dividend first.
REQ-018 Each restoring step SHALL work as follows:
- Shift the partial remainder (D_W+1 bits) left and insert the next dividend bit.
- Compute trial = partial - divisor.
- If trial is non-negative: the quotient bit is 1 and partial becomes trial.
- Otherwise: the quotient bit is 0 and partial is unchanged.
REQ-019 After the N_W-th step the block SHALL enter DONE. out_valid SHALL therefore rise N_W edges after the accept edge (4 cycles at default widths).
REQ-020 On accept with divisor == 0, the block SHALL enter DONE on the next edge with:
- quotient = all ones
- remainder = 0
- div_by_zero = 1
REQ-021 In DONE, quotient, remainder and div_by_zero SHALL be held stable while out_ready = 0.
REQ-022 On an edge where out_valid && out_ready, the block SHALL return to IDLE. in_ready SHALL be 1 in the following cycle; back-to-back overlap is not supported.
REQ-023 The result SHALL satisfy quotient*divisor + remainder == dividend and remainder < divisor for every nonzero divisor.
REQ-024 in_valid asserted while not in IDLE SHALL be ignored, with no change to latched operands.
REQ-025 Changes on dividend or divisor after accept SHALL NOT affect the result in flight.

Reset
REQ-026 While rst_n = 0, all outputs and internal registers SHALL clear immediately:
- state = IDLE, in_ready = 1 after release, out_valid = 0
- quotient = 0, remainder = 0, div_by_zero = 0
- step counter = 0
REQ-027 Reset asserted during BUSY or DONE SHALL discard the operation in flight; no out_valid pulse SHALL follow reset release.

Structure
REQ-028 Package div_pkg SHALL hold:
- the state encoding (IDLE/BUSY/DONE)
- default N_W/D_W constants
- the step-counter width constant, clog2(N_W+1)
REQ-029 One combinational sub-module, divider_step, SHALL implement a single restoring step. Its ports are partial_in, next_bit and divisor in; partial_out and q_bit out. It SHALL be instantiated once and reused each BUSY cycle.
REQ-030 The top level SHALL contain only the FSM, the counter, the operand/result registers and the handshake logic.

Verification
REQ-031 11 / 3, out_ready = 1 -> after 4 cycles out_valid = 1, quotient = 3, remainder = 2, div_by_zero = 0.
REQ-032 15 / 1 -> quotient = 15, remainder = 0, and 0 / 2 -> quotient = 0, remainder = 0, each after 4 cycles.
REQ-033 9 / 0 -> out_valid one edge after accept, quotient = 15, remainder = 0, div_by_zero = 1.
REQ-034 Backpressure and ignored input:
- 14 / 3 with out_ready held 0 for 3 cycles -> outputs hold quotient = 4, remainder = 2 throughout.
- A second in_valid during BUSY or DONE is ignored.
- IDLE is reached on the out_ready edge.
REQ-035 rst_n pulled low at BUSY step 2 of 13 / 2 -> outputs clear immediately. No out_valid after release. A following 6 / 3 yields quotient = 2, remainder = 0.
REQ-036 Exhaustive sweep over all 16 x 4 operand pairs, cross-checked against the 2x2 multiplier model:
- quotient*divisor + remainder == dividend for every nonzero divisor
- the div_by_zero rules for divisor == 0
